// File: rtl/mdu_hilo.sv
// Iterative multiply/divide unit with HI/LO registers.
// Shift-add multiply and restoring divide share one 64-bit accumulator.
module mdu_hilo #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [5:0]      funct,
    input  logic [XLEN-1:0] rs_val,
    input  logic [XLEN-1:0] rt_val,
    output logic            busy,
    output logic            done,
    output logic            div_zero,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic [XLEN-1:0] mf_data
);

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX
    } state_t;

    state_t            state_q;
    logic [4:0]        cnt_q;
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   opa_q;
    logic [XLEN-1:0]   opb_q;
    logic              neg_a_q;
    logic              neg_b_q;
    logic              is_div_q;
    logic [XLEN-1:0]   hi_q;
    logic [XLEN-1:0]   lo_q;
    logic              busy_q;
    logic              done_q;
    logic              dz_q;

    // Request decode
    logic f_mul;
    logic f_div;
    logic f_mthi;
    logic f_mtlo;
    logic f_signed;

    assign f_mul    = (funct == F_MULT) || (funct == F_MULTU);
    assign f_div    = (funct == F_DIV) || (funct == F_DIVU);
    assign f_mthi   = (funct == F_MTHI);
    assign f_mtlo   = (funct == F_MTLO);
    assign f_signed = (funct == F_MULT) || (funct == F_DIV);

    logic            rs_neg;
    logic            rt_neg;
    logic [XLEN-1:0] rs_mag;
    logic [XLEN-1:0] rt_mag;

    assign rs_neg = f_signed & rs_val[XLEN-1];
    assign rt_neg = f_signed & rt_val[XLEN-1];
    assign rs_mag = rs_neg ? -rs_val : rs_val;
    assign rt_mag = rt_neg ? -rt_val : rt_val;

    // Multiply step: conditional add into the upper half, then shift right
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_acc_d;

    assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]}
                     + (acc_q[0] ? {1'b0, opa_q} : '0);
    assign mul_acc_d = {mul_sum, acc_q[XLEN-1:1]};

    // Restoring divide step: remainder high, dividend/quotient low
    logic [XLEN:0]     div_sh;
    logic [XLEN:0]     div_sub;
    logic              div_ge;
    logic [XLEN-1:0]   div_rem;
    logic [2*XLEN-1:0] div_acc_d;

    assign div_sh    = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign div_ge    = div_sh >= {1'b0, opb_q};
    assign div_sub   = div_sh - {1'b0, opb_q};
    assign div_rem   = div_ge ? div_sub[XLEN-1:0] : div_sh[XLEN-1:0];
    assign div_acc_d = {div_rem, acc_q[XLEN-2:0], div_ge};

    // The subtract result is below the divisor, so its top bit is dead
    logic unused_sub;
    assign unused_sub = div_sub[XLEN];

    // Sign correction and divide-by-zero substitution
    logic              neg_res;
    logic              fix_dz;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   rs_back;
    logic [XLEN-1:0]   fix_hi;
    logic [XLEN-1:0]   fix_lo;

    assign neg_res  = neg_a_q ^ neg_b_q;
    assign fix_dz   = is_div_q && (opb_q == '0);
    assign prod_fix = neg_res ? -acc_q : acc_q;
    assign quo_fix  = neg_res ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    assign rem_fix  = neg_a_q ? -acc_q[2*XLEN-1:XLEN]
                              : acc_q[2*XLEN-1:XLEN];
    assign rs_back  = neg_a_q ? -opa_q : opa_q;

    always_comb begin
        fix_hi = prod_fix[2*XLEN-1:XLEN];
        fix_lo = prod_fix[XLEN-1:0];
        if (fix_dz) begin
            fix_hi = rs_back;
            fix_lo = '1;
        end else if (is_div_q) begin
            fix_hi = rem_fix;
            fix_lo = quo_fix;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            is_div_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dz_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        unique case (1'b1)
                            f_mul: begin
                                opa_q    <= rs_mag;
                                opb_q    <= rt_mag;
                                neg_a_q  <= rs_neg;
                                neg_b_q  <= rt_neg;
                                is_div_q <= 1'b0;
                                acc_q    <= {{XLEN{1'b0}}, rt_mag};
                                cnt_q    <= '0;
                                busy_q   <= 1'b1;
                                state_q  <= S_MUL;
                            end
                            f_div: begin
                                opa_q    <= rs_mag;
                                opb_q    <= rt_mag;
                                neg_a_q  <= rs_neg;
                                neg_b_q  <= rt_neg;
                                is_div_q <= 1'b1;
                                acc_q    <= {{XLEN{1'b0}}, rs_mag};
                                cnt_q    <= '0;
                                busy_q   <= 1'b1;
                                state_q  <= S_DIV;
                            end
                            f_mthi: hi_q <= rs_val;
                            f_mtlo: lo_q <= rs_val;
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    acc_q <= mul_acc_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) state_q <= S_FIX;
                end
                S_DIV: begin
                    acc_q <= div_acc_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) state_q <= S_FIX;
                end
                S_FIX: begin
                    hi_q    <= fix_hi;
                    lo_q    <= fix_lo;
                    done_q  <= 1'b1;
                    dz_q    <= fix_dz;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = dz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

    assign mf_data = (funct == F_MFHI) ? hi_q :
                     (funct == F_MFLO) ? lo_q : '0;

endmodule

// File: tb/tb_mdu_hilo.sv
// Scoreboard bench for mdu_hilo: directed ops, monitor checks each done.
`timescale 1ns/1ps
module tb_mdu_hilo;

    localparam logic [5:0] F_NONE  = 6'b000000;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  funct = F_NONE;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mf_data;

    mdu_hilo #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .funct(funct),
        .rs_val(rs_val), .rt_val(rt_val), .busy(busy), .done(done),
        .div_zero(div_zero), .hi(hi), .lo(lo), .mf_data(mf_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        longint      t0;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] eh, input logic [31:0] el,
                            input logic ez, input longint t0);
        exp_t e;
        e.hi = eh;
        e.lo = el;
        e.dz = ez;
        e.t0 = t0;
        sb.push_back(e);
    endtask

    // Drives one request across a single clock edge
    task automatic issue(input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic push,
                         input logic [31:0] eh, input logic [31:0] el,
                         input logic ez);
        start  = 1'b1;
        funct  = f;
        rs_val = a;
        rt_val = b;
        @(posedge clk);
        if (push) push_exp(eh, el, ez, longint'($time));
        #1;
        start = 1'b0;
        funct = F_NONE;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || sb.size() != 0) && n < 80);
        if (busy || sb.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL %s_timeout: busy=%0d pending=%0d", name, busy,
                     sb.size());
            sb.delete();
        end
    endtask

    // Monitor: every done pulse must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL unexpected_done: hi=%h lo=%h", hi, lo);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("res_hi", hi, e.hi);
                check("res_lo", lo, e.lo);
                check("res_dz", 32'(div_zero), 32'(e.dz));
                check("res_latency", 32'($time - e.t0), 32'd335);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        #2;
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_dz", 32'(div_zero), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Abort a multiply with reset part-way through
        @(posedge clk);
        #1;
        issue(F_MULT, 32'd7, 32'd6, 1'b0, '0, '0, 1'b0);
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_done", 32'(done), 32'h0);
        check("abort_hi", hi, 32'h0);
        check("abort_lo", lo, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("after_abort_busy", 32'(busy), 32'h0);
        check("after_abort_hi", hi, 32'h0);
        check("after_abort_lo", lo, 32'h0);

        // Multiply
        @(posedge clk);
        #1;
        issue(F_MULT, 32'hFFFFFFFD, 32'd5, 1'b1,
              32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
        wait_idle("mult");
        issue(F_MULTU, 32'hFFFFFFFF, 32'd2, 1'b1,
              32'h00000001, 32'hFFFFFFFE, 1'b0);
        funct = F_MFHI;
        @(negedge clk);
        check("mf_old_during_busy", mf_data, 32'hFFFFFFFF);
        check("busy_during_op", 32'(busy), 32'h1);
        funct = F_NONE;
        wait_idle("multu");

        // Divide, including zero divisor and signed overflow
        issue(F_DIV, 32'hFFFFFFF9, 32'd2, 1'b1,
              32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        wait_idle("div");
        issue(F_DIVU, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14, 1'b0);
        wait_idle("divu");
        issue(F_DIV, 32'd123, 32'd0, 1'b1, 32'd123, 32'hFFFFFFFF, 1'b1);
        wait_idle("div0");
        issue(F_DIV, 32'hFFFFFF85, 32'd0, 1'b1,
              32'hFFFFFF85, 32'hFFFFFFFF, 1'b1);
        wait_idle("div0_neg");
        issue(F_DIVU, 32'hFFFFFF85, 32'd0, 1'b1,
              32'hFFFFFF85, 32'hFFFFFFFF, 1'b1);
        wait_idle("divu0");
        issue(F_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b1,
              32'h0, 32'h80000000, 1'b0);
        wait_idle("div_ovf");

        // Move-to while busy is dropped; accepted once idle
        issue(F_MULT, 32'd3, 32'd4, 1'b1, 32'h0, 32'd12, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        issue(F_MTLO, 32'hDEADBEEF, 32'h0, 1'b0, '0, '0, 1'b0);
        wait_idle("mt_busy");
        issue(F_MTLO, 32'hDEADBEEF, 32'h0, 1'b0, '0, '0, 1'b0);
        funct = F_MFLO;
        @(negedge clk);
        check("mflo_after_mtlo", mf_data, 32'hDEADBEEF);
        check("mt_no_done", 32'(done), 32'h0);
        check("mt_no_busy", 32'(busy), 32'h0);
        funct = F_NONE;
        @(posedge clk);
        #1;
        issue(F_MTHI, 32'h13579BDF, 32'h0, 1'b0, '0, '0, 1'b0);
        funct = F_MFHI;
        @(negedge clk);
        check("mfhi_after_mthi", mf_data, 32'h13579BDF);
        funct = F_NONE;
        @(negedge clk);
        check("mf_other_funct", mf_data, 32'h0);

        // Back-to-back: second start held through the done cycle
        @(posedge clk);
        #1;
        issue(F_DIVU, 32'd9, 32'd3, 1'b1, 32'h0, 32'd3, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 60);
        if (!done) begin
            errors++;
            checks++;
            $display("FAIL b2b_done_timeout: done=%0d", done);
        end
        start  = 1'b1;
        funct  = F_MULTU;
        rs_val = 32'd2;
        rt_val = 32'd2;
        push_exp(32'h0, 32'd4, 1'b0, longint'($time) + 5);
        @(posedge clk);
        #1;
        start = 1'b0;
        funct = F_NONE;
        check("b2b_accepted_busy", 32'(busy), 32'h1);
        wait_idle("b2b");

        check("sb_drained", 32'(sb.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
